regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/common_pkg.sv | 25 ++
 rtl/regfile_scoreboard.sv | 38 +++
 rtl/regfile_mp.sv | 98 +++++++++
 tb/tb_regfile_mp.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared core types (word and architectural register address) plus register-file defaults.
package common;

    localparam int unsigned XLEN         = 64;
    localparam int unsigned CREG_ADDR_W  = 5;
    localparam int unsigned NREG_DEFAULT = 32;

    typedef logic [XLEN-1:0]        word_t;
    typedef logic [CREG_ADDR_W-1:0] creg_addr_t;

    localparam creg_addr_t REG_ZERO = '0;

    // One write-port transaction as seen inside the register file.
    typedef struct packed {
        logic       valid;
        creg_addr_t addr;
        word_t      data;
    } wr_req_t;

    // True for an address that names a real, writable register.
    function automatic logic reg_ok(input creg_addr_t a, input int unsigned n);
        return (a != REG_ZERO) && (32'(a) < n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set at issue, cleared by writeback, wiped by flush.
module regfile_scoreboard
    import common::*;
#(
    parameter int unsigned NREG = NREG_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_valid,
    input  creg_addr_t       set_addr,
    input  logic [NREG-1:0]  clr,
    input  logic             flush,
    output logic [NREG-1:0]  busy
);

    logic [NREG-1:0] busy_nxt;

    // Set is applied after clear (newer producer wins); flush overrides both.
    always_comb begin
        busy_nxt = busy & ~clr;
        if (set_valid && reg_ok(set_addr, NREG)) begin
            busy_nxt[set_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported 64-bit register file with issue scoreboard; r0 reads as zero.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import common::*;
#(
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 1,
    parameter int unsigned NREG   = NREG_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  creg_addr_t        ra [NREAD],
    output word_t             rd [NREAD],
    output logic [NREAD-1:0]  rbusy,
    input  logic [NWRITE-1:0] wvalid,
    input  creg_addr_t        wa [NWRITE],
    input  word_t             wd [NWRITE],
    input  logic              set_valid,
    input  creg_addr_t        set_addr,
    input  logic              flush
);

    wr_req_t         wr [NWRITE];
    word_t           regs [NREG];
    word_t           regs_nxt [NREG];
    logic [NREG-1:0] wr_clr;
    logic [NREG-1:0] busy;

    always_comb begin
        for (int j = 0; j < NWRITE; j++) begin
            wr[j] = '{valid: wvalid[j], addr: wa[j], data: wd[j]};
        end
    end

    // Ports applied in ascending order so the highest-index port wins a collision.
    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            regs_nxt[k] = regs[k];
        end
        wr_clr = '0;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr[j].valid && reg_ok(wr[j].addr, NREG)) begin
                regs_nxt[wr[j].addr] = wr[j].data;
                wr_clr[wr[j].addr]   = 1'b1;
            end
        end
        regs_nxt[0] = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= regs_nxt[k];
            end
        end
    end

    regfile_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_valid (set_valid),
        .set_addr  (set_addr),
        .clr       (wr_clr),
        .flush     (flush),
        .busy      (busy)
    );

    // Combinational read ports; forced to zero while reset is held.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd[i]    = '0;
            rbusy[i] = 1'b0;
            if (reg_ok(ra[i], NREG)) begin
                rd[i]    = regs[ra[i]];
                rbusy[i] = busy[ra[i]];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NWRITE; j++) begin
                    if (wr[j].valid && (wr[j].addr == ra[i])) begin
                        rd[i]    = wr[j].data;
                        rbusy[i] = 1'b0;
                    end
                end
`else
`endif
            end
            if (!reset) begin
                rd[i] = '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus random checks of regfile_mp against an array-based reference model.
module tb_regfile_mp;
    import common::*;

    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;
    localparam int unsigned NG = 32;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    creg_addr_t     ra [NR];
    word_t          rd [NR];
    logic [NR-1:0]  rbusy;
    logic [NW-1:0]  wvalid;
    creg_addr_t     wa [NW];
    word_t          wd [NW];
    logic           set_valid;
    creg_addr_t     set_addr;
    logic           flush;

    int tests = 0;
    int fails = 0;

    word_t m_regs [NG];
    bit    m_busy [NG];

    always #5 clk = ~clk;

    regfile_mp #(
        .NREAD  (NR),
        .NWRITE (NW),
        .NREG   (NG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ra        (ra),
        .rd        (rd),
        .rbusy     (rbusy),
        .wvalid    (wvalid),
        .wa        (wa),
        .wd        (wd),
        .set_valid (set_valid),
        .set_addr  (set_addr),
        .flush     (flush)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t exp_rd(input int i);
        word_t v;
        if (!reset || ra[i] == 0) return '0;
        v = m_regs[ra[i]];
        if (BYPASS) begin
            for (int j = 0; j < NW; j++) begin
                if (wvalid[j] && wa[j] == ra[i]) v = wd[j];
            end
        end
        return v;
    endfunction

    function automatic bit exp_busy(input int i);
        bit b;
        if (!reset || ra[i] == 0) return 1'b0;
        b = m_busy[ra[i]];
        if (BYPASS) begin
            for (int j = 0; j < NW; j++) begin
                if (wvalid[j] && wa[j] == ra[i]) b = 1'b0;
            end
        end
        return b;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NG; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end
    endtask

    // Edge effect: writes in port order, then newer set, then flush.
    task automatic model_commit();
        for (int j = 0; j < NW; j++) begin
            if (wvalid[j] && wa[j] != 0) begin
                m_regs[wa[j]] = wd[j];
                m_busy[wa[j]] = 1'b0;
            end
        end
        if (set_valid && set_addr != 0) m_busy[set_addr] = 1'b1;
        if (flush) begin
            for (int k = 0; k < NG; k++) m_busy[k] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_commit();
        #1;
    endtask

    task automatic idle();
        wvalid    = '0;
        set_valid = 1'b0;
        set_addr  = '0;
        flush     = 1'b0;
        for (int j = 0; j < NW; j++) begin
            wa[j] = '0;
            wd[j] = '0;
        end
    endtask

    task automatic check_reads(input string tag);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("%s_rd%0d", tag, i), rd[i], exp_rd(i));
            check($sformatf("%s_busy%0d", tag, i), 64'(rbusy[i]), 64'(exp_busy(i)));
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        model_clear();
        ra[0] = 5'd5;
        ra[1] = 5'd3;
        #1;
        check("reset_rd0", rd[0], 64'h0);
        check("reset_busy", 64'(rbusy), 64'h0);

        // First edge after reset release performs the write.
        #1;
        reset     = 1'b1;
        wvalid[0] = 1'b1;
        wa[0]     = 5'd5;
        wd[0]     = 64'hDEAD_BEEF;
        #1;
        check_reads("first");
        tick();
        idle();
        ra[0] = 5'd5;
        ra[1] = 5'd0;
        #1;
        check("wr5_rd0", rd[0], 64'hDEAD_BEEF);
        check("wr5_rd1_r0", rd[1], 64'h0);

        // Write to r0 is dropped.
        wvalid[0] = 1'b1;
        wa[0]     = 5'd0;
        wd[0]     = 64'h1234;
        ra[0]     = 5'd0;
        #1;
        check("r0_rd", rd[0], 64'h0);
        check("r0_regs_nxt", dut.regs_nxt[0], 64'h0);
        tick();
        idle();
        #1;
        check("r0_rd_after", rd[0], 64'h0);

        // Two ports hit r7; port 1 wins.
        wvalid = 2'b11;
        wa[0]  = 5'd7;
        wd[0]  = 64'h11;
        wa[1]  = 5'd7;
        wd[1]  = 64'h22;
        ra[0]  = 5'd7;
        #1;
        check_reads("dual");
        tick();
        idle();
        #1;
        check("dual_r7", rd[0], 64'h22);

        // Scoreboard set / clear / set-beats-clear on r3.
        set_valid = 1'b1;
        set_addr  = 5'd3;
        tick();
        idle();
        ra[0] = 5'd3;
        #1;
        check("sb_set3", 64'(rbusy[0]), 64'h1);
        wvalid[0] = 1'b1;
        wa[0]     = 5'd3;
        wd[0]     = 64'h33;
        #1;
        check_reads("sb_wr3");
        tick();
        idle();
        #1;
        check("sb_clr3", 64'(rbusy[0]), 64'h0);
        set_valid = 1'b1;
        set_addr  = 5'd3;
        wvalid[0] = 1'b1;
        wa[0]     = 5'd3;
        wd[0]     = 64'h34;
        tick();
        idle();
        #1;
        check("sb_setwins3", 64'(rbusy[0]), 64'h1);
        check("sb_setwins3_rd", rd[0], 64'h34);

        // Same-cycle read of a write to r9.
        wvalid[0] = 1'b1;
        wa[0]     = 5'd9;
        wd[0]     = 64'h55;
        ra[0]     = 5'd9;
        #1;
        check("byp_r9", rd[0], BYPASS ? 64'h55 : 64'h0);
        tick();
        idle();
        #1;
        check("byp_r9_next", rd[0], 64'h55);

        // Busy r4, r6, then asynchronous reset mid-cycle.
        set_valid = 1'b1;
        set_addr  = 5'd4;
        tick();
        set_addr  = 5'd6;
        tick();
        idle();
        ra[0] = 5'd4;
        ra[1] = 5'd6;
        #1;
        check("busy46", 64'(rbusy), 64'h3);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check("arst_busy", 64'(rbusy), 64'h0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ra[0] = creg_addr_t'(2 * k);
            ra[1] = creg_addr_t'(2 * k + 1);
            #1;
            check($sformatf("arst_rd%0d", 2 * k), rd[0], 64'h0);
            check($sformatf("arst_rd%0d", 2 * k + 1), rd[1], 64'h0);
            check($sformatf("arst_busy%0d", k), 64'(rbusy), 64'h0);
        end
        #1;
        reset = 1'b1;
        tick();
        ra[0] = 5'd5;
        ra[1] = 5'd7;
        #1;
        check("post_rst_r5", rd[0], 64'h0);
        check("post_rst_r7", rd[1], 64'h0);

        // Flush overrides a same-cycle set; its write still commits.
        set_valid = 1'b1;
        set_addr  = 5'd2;
        tick();
        idle();
        set_valid = 1'b1;
        set_addr  = 5'd8;
        flush     = 1'b1;
        wvalid[0] = 1'b1;
        wa[0]     = 5'd2;
        wd[0]     = 64'hABC;
        tick();
        idle();
        ra[0] = 5'd8;
        ra[1] = 5'd2;
        #1;
        check("flush_busy", 64'(rbusy), 64'h0);
        check("flush_wr2", rd[1], 64'hABC);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) ra[i] = creg_addr_t'($urandom_range(0, 15));
            for (int j = 0; j < NW; j++) begin
                wvalid[j] = 1'($urandom_range(0, 1));
                wa[j]     = creg_addr_t'($urandom_range(0, 15));
                wd[j]     = {$urandom, $urandom};
            end
            set_valid = 1'($urandom_range(0, 1));
            set_addr  = creg_addr_t'($urandom_range(0, 15));
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            check_reads($sformatf("rnd%0d", n));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
